// File: rtl/fp_pkg.sv
// Shared constants for the pipelined floating-point adder: default field
// widths, derived bias, special encodings and flag bit positions.
package fp_pkg;

  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 23;
  localparam int unsigned DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;
  localparam int unsigned DEF_BIAS  = (1 << (DEF_EXP_W - 1)) - 1;

  localparam logic [DEF_W-1:0] DEF_QNAN =
      {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W - 1){1'b0}}};
  localparam logic [DEF_W-1:0] DEF_POS_INF =
      {1'b0, {DEF_EXP_W{1'b1}}, {DEF_MAN_W{1'b0}}};

  // flags = {invalid, overflow, underflow, inexact, zero}
  localparam int unsigned FLAG_W         = 5;
  localparam int unsigned FLAG_INVALID   = 4;
  localparam int unsigned FLAG_OVERFLOW  = 3;
  localparam int unsigned FLAG_UNDERFLOW = 2;
  localparam int unsigned FLAG_INEXACT   = 1;
  localparam int unsigned FLAG_ZERO      = 0;

endpackage

// File: rtl/fp_round_norm.sv
// Final stage datapath: leading-zero count, normalisation, round-to-nearest-
// even and packing of zero/overflow/underflow results.
module fp_round_norm
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input  logic                   sign_i,
  input  logic                   zero_sign_i,
  input  logic [EXP_W-1:0]       exp_i,
  input  logic [MAN_W+4:0]       sum_i,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic [FLAG_W-1:0]      flags_o
);

  // sum_i layout: [SW] carry, [SW-1] hidden bit, mantissa, guard, round, sticky
  localparam int unsigned SW      = MAN_W + 4;
  localparam int unsigned LZ_W    = $clog2(SW + 1);
  localparam int unsigned XW      = EXP_W + 2;
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

  logic [LZ_W-1:0]  lz;
  logic [SW-1:0]    norm;
  logic [XW-1:0]    exp_n;
  logic [XW-1:0]    exp_r;
  logic [MAN_W:0]   sig;
  logic             guard;
  logic             rnd;
  logic             sticky;
  logic             round_up;
  logic [MAN_W+1:0] rounded;
  logic [MAN_W-1:0] man_r;

  // Leading-zero count of the field below the carry bit
  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++) begin
      if (sum_i[i]) lz = LZ_W'(SW - 1 - i);
    end
  end

  // Normalise, round to nearest even and pack the exceptional cases
  always_comb begin
    if (sum_i[SW]) begin
      // Carry out: shift right once, folding the dropped bit into sticky
      norm  = {sum_i[SW:2], sum_i[1] | sum_i[0]};
      exp_n = {2'b00, exp_i} + XW'(1);
    end else begin
      norm  = sum_i[SW-1:0] << lz;
      exp_n = {2'b00, exp_i} - XW'(lz);
    end

    sig      = norm[SW-1:3];
    guard    = norm[2];
    rnd      = norm[1];
    sticky   = norm[0];
    round_up = guard & (rnd | sticky | sig[0]);
    rounded  = {1'b0, sig} + (MAN_W + 2)'(round_up);

    if (rounded[MAN_W+1]) begin
      man_r = rounded[MAN_W:1];
      exp_r = exp_n + XW'(1);
    end else begin
      man_r = rounded[MAN_W-1:0];
      exp_r = exp_n;
    end

    result_o = '0;
    flags_o  = '0;
    if (sum_i == '0) begin
      result_o           = {zero_sign_i, {(EXP_W + MAN_W){1'b0}}};
      flags_o[FLAG_ZERO] = 1'b1;
    end else if ($signed(exp_r) >= $signed(XW'(EXP_MAX))) begin
      result_o               = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_o[FLAG_OVERFLOW] = 1'b1;
      flags_o[FLAG_INEXACT]  = 1'b1;
    end else if ($signed(exp_r) <= $signed(XW'(0))) begin
      result_o                = {sign_i, {(EXP_W + MAN_W){1'b0}}};
      flags_o[FLAG_UNDERFLOW] = 1'b1;
      flags_o[FLAG_INEXACT]   = 1'b1;
      flags_o[FLAG_ZERO]      = 1'b1;
    end else begin
      result_o              = {sign_i, exp_r[EXP_W-1:0], man_r};
      flags_o[FLAG_INEXACT] = guard | rnd | sticky;
    end
  end

endmodule

// File: rtl/fp_adder_pipe.sv
// Three-stage floating-point adder/subtractor with a single global stall.
// S1 unpack/classify/align, S2 mantissa add/sub, S3 normalise/round/pack.
module fp_adder_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [FLAG_W-1:0]    flags
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned SW   = MAN_W + 4;
  localparam int unsigned SUMW = MAN_W + 5;
  localparam int unsigned SH_W = $clog2(SW + 1);

  localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic advance;
  logic v1_q, v2_q, v3_q;
  logic [W-1:0]      result_q;
  logic [FLAG_W-1:0] flags_q;

  // S1 combinational signals
  logic             sa, sb, sl, ss;
  logic [EXP_W-1:0] ea, eb, el, es, diff;
  logic [MAN_W-1:0] ma, mb, ml, ms;
  logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
  logic             swap;
  logic [SW-1:0]    ext_s;
  logic [SH_W-1:0]  shamt;
  logic [2*SW-1:0]  wide;
  logic [SW-1:0]    sig_l_d, sig_s_d;
  logic             special_d, invalid_d;
  logic [W-1:0]     spec_res_d;

  // S1 registers
  logic             s1_special, s1_invalid, s1_sign, s1_sub, s1_zsign;
  logic [W-1:0]     s1_spec_res;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_sig_l, s1_sig_s;

  // S2 registers
  logic             s2_special, s2_invalid, s2_sign, s2_zsign;
  logic [W-1:0]     s2_spec_res;
  logic [EXP_W-1:0] s2_exp;
  logic [SUMW-1:0]  s2_sum;
  logic [SUMW-1:0]  sum_d;

  // S3 signals
  logic [W-1:0]      rn_result, res_d;
  logic [FLAG_W-1:0] rn_flags, flags_d;

  assign advance   = !v3_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // S1: unpack, classify, order by magnitude and align the smaller operand
  always_comb begin
    sa = a[W-1];
    sb = b[W-1] ^ op;
    ea = a[W-2:MAN_W];
    eb = b[W-2:MAN_W];
    // Denormals flush to zero
    ma = (ea == '0) ? '0 : a[MAN_W-1:0];
    mb = (eb == '0) ? '0 : b[MAN_W-1:0];

    a_nan  = (ea == EXP_ONES) & (|ma);
    b_nan  = (eb == EXP_ONES) & (|mb);
    a_snan = a_nan & ~ma[MAN_W-1];
    b_snan = b_nan & ~mb[MAN_W-1];
    a_inf  = (ea == EXP_ONES) & ~(|ma);
    b_inf  = (eb == EXP_ONES) & ~(|mb);

    swap = {eb, mb} > {ea, ma};
    if (swap) begin
      sl = sb; el = eb; ml = mb;
      ss = sa; es = ea; ms = ma;
    end else begin
      sl = sa; el = ea; ml = ma;
      ss = sb; es = eb; ms = mb;
    end

    diff    = el - es;
    ext_s   = {|es, ms, 3'b000};
    shamt   = (32'(diff) >= SW) ? SH_W'(SW) : SH_W'(diff);
    // Shift into a double-width window; everything below SW folds into sticky
    wide    = {ext_s, {SW{1'b0}}} >> shamt;
    sig_s_d = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
    sig_l_d = {|el, ml, 3'b000};

    special_d  = a_nan | b_nan | a_inf | b_inf;
    spec_res_d = QNAN;
    invalid_d  = 1'b0;
    if (a_nan | b_nan) begin
      invalid_d = a_snan | b_snan;
    end else if (a_inf & b_inf & (sa ^ sb)) begin
      invalid_d = 1'b1;
    end else if (a_inf) begin
      spec_res_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_res_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  // S2: magnitude add or subtract; larger operand first so never negative
  assign sum_d = s1_sub ? ({1'b0, s1_sig_l} - {1'b0, s1_sig_s})
                        : ({1'b0, s1_sig_l} + {1'b0, s1_sig_s});

  fp_round_norm #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round_norm (
    .sign_i     (s2_sign),
    .zero_sign_i(s2_zsign),
    .exp_i      (s2_exp),
    .sum_i      (s2_sum),
    .result_o   (rn_result),
    .flags_o    (rn_flags)
  );

  // S3: special-case results bypass the rounding path
  always_comb begin
    res_d   = rn_result;
    flags_d = rn_flags;
    if (s2_special) begin
      res_d                 = s2_spec_res;
      flags_d               = '0;
      flags_d[FLAG_INVALID] = s2_invalid;
    end
  end

  // Stage valid bits and output registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (advance) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) begin
        result_q <= res_d;
        flags_q  <= flags_d;
      end
    end
  end

  // Datapath stage registers, qualified only by the stall
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_special  <= special_d;
      s1_invalid  <= invalid_d;
      s1_spec_res <= spec_res_d;
      s1_sign     <= sl;
      s1_sub      <= sl ^ ss;
      s1_zsign    <= sl & ss;
      s1_exp      <= el;
      s1_sig_l    <= sig_l_d;
      s1_sig_s    <= sig_s_d;

      s2_special  <= s1_special;
      s2_invalid  <= s1_invalid;
      s2_spec_res <= s1_spec_res;
      s2_sign     <= s1_sign;
      s2_zsign    <= s1_zsign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum_d;
    end
  end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Scoreboard bench for fp_adder_pipe: directed vectors, latency, stall and
// mid-stream reset behaviour.
module tb_fp_adder_pipe;
  import fp_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] ONE = {1'b0, 8'(DEF_BIAS), 23'b0};

  typedef struct packed {
    logic [W-1:0] res;
    logic [4:0]   flg;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vop;
    logic [W-1:0] res;
    logic [4:0]   flg;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [4:0]   flags;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fp_adder_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One cycle: wait for the edge, apply inputs, let them settle
  task automatic drive(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic opi, input logic ordy, input logic rst,
                       output logic acc);
    @(posedge clk);
    #1;
    rst_n     = rst;
    in_valid  = v;
    a         = ai;
    b         = bi;
    op        = opi;
    out_ready = ordy;
    #1;
    acc = v & in_ready & rst;
  endtask

  task automatic test_reset();
    logic acc;
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    total++;
    if (result !== '0) begin
      bad++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    total++;
    if (flags !== '0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0", flags);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    vec_t vecs[14];
    logic acc;
    logic got;
    int   lat;
    vecs[0]  = {ONE, ONE, 1'b0, 32'h4000_0000, 5'b00000};
    vecs[1]  = {ONE, ONE, 1'b1, 32'h0000_0000, 5'b00001};
    vecs[2]  = {ONE, 32'h3380_0000, 1'b0, ONE, 5'b00010};
    vecs[3]  = {ONE, 32'h3440_0000, 1'b0, 32'h3F80_0002, 5'b00010};
    vecs[4]  = {32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, DEF_POS_INF, 5'b01010};
    vecs[5]  = {DEF_POS_INF, 32'hFF80_0000, 1'b0, DEF_QNAN, 5'b10000};
    vecs[6]  = {32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 5'b00001};
    vecs[7]  = {DEF_POS_INF, ONE, 1'b0, DEF_POS_INF, 5'b00000};
    vecs[8]  = {32'h7FC0_0001, ONE, 1'b0, DEF_QNAN, 5'b00000};
    vecs[9]  = {32'h7F80_0001, ONE, 1'b0, DEF_QNAN, 5'b10000};
    vecs[10] = {32'h0000_0001, ONE, 1'b0, ONE, 5'b00000};
    vecs[11] = {32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h8000_0000, 5'b00111};
    vecs[12] = {DEF_POS_INF, DEF_POS_INF, 1'b1, DEF_QNAN, 5'b10000};
    vecs[13] = {ONE, 32'h3FC0_0000, 1'b1, 32'hBF00_0000, 5'b00000};
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].va, vecs[i].vb, vecs[i].vop, 1'b1, 1'b1, acc);
      total++;
      if (acc !== 1'b1) begin
        bad++;
        $display("FAIL basic_accept[%0d]: in_ready %b want 1", i, in_ready);
      end else begin
        sb_q.push_back({vecs[i].res, vecs[i].flg});
      end
      got = 1'b0;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
        if (out_valid && !got) begin
          got = 1'b1;
          lat = c;
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL basic_unexpected[%0d]: result %h with empty scoreboard", i, result);
          end else begin
            if ({result, flags} !== sb_q[0]) begin
              bad++;
              $display("FAIL basic_value[%0d]: got %h/%b want %h/%b", i, result, flags,
                       sb_q[0].res, sb_q[0].flg);
            end
            void'(sb_q.pop_front());
          end
          total++;
          if (lat != 3) begin
            bad++;
            $display("FAIL basic_latency[%0d]: got %0d want 3", i, lat);
          end
        end else if (out_valid) begin
          total++;
          bad++;
          $display("FAIL basic_duplicate[%0d]: extra result %h", i, result);
        end
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL basic_timeout[%0d]: no out_valid within 8 cycles", i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int           idx = 0;
    int           popped = 0;
    int           stall_seen = 0;
    logic         acc;
    logic         ordy;
    logic [7:0]   ex;
    logic [W-1:0] va, vb;
    logic         vop;
    exp_t         e;
    for (int c = 0; c < 80 && popped < 10; c++) begin
      ex  = 8'(120 + idx);
      va  = {1'b0, ex, 23'h0};
      vb  = {1'b0, ex, 23'h0};
      vop = 1'b0;
      e   = {1'b0, ex + 8'd1, 23'h0, 5'b00000};
      if (idx % 3 == 1) begin
        va = {1'b0, ex, 23'h400000};
        e  = {1'b0, ex + 8'd1, 23'h200000, 5'b00000};
      end else if (idx % 3 == 2) begin
        va  = {1'b0, ex, 23'h400000};
        vop = 1'b1;
        e   = {1'b0, ex - 8'd1, 23'h0, 5'b00000};
      end
      ordy = !(c >= 4 && c < 9);
      drive(idx < 10, va, vb, vop, ordy, 1'b1, acc);
      if (!ordy && out_valid) begin
        stall_seen++;
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_stall_in_ready: cycle %0d got %b want 0", c, in_ready);
        end
      end
      if (out_valid) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_unexpected: cycle %0d result %h", c, result);
        end else begin
          if ({result, flags} !== sb_q[0]) begin
            bad++;
            $display("FAIL b2b_value: cycle %0d got %h/%b want %h/%b", c, result, flags,
                     sb_q[0].res, sb_q[0].flg);
          end
          if (out_ready) begin
            void'(sb_q.pop_front());
            popped++;
          end
        end
      end
      if (acc) begin
        sb_q.push_back(e);
        idx++;
      end
    end
    total++;
    if (popped != 10) begin
      bad++;
      $display("FAIL b2b_count: got %0d results want 10", popped);
    end
    total++;
    if (stall_seen != 5) begin
      bad++;
      $display("FAIL b2b_stall_cycles: got %0d stalled cycles want 5", stall_seen);
    end
  endtask

  task automatic test_reset_flush();
    logic acc;
    logic got;
    sb_q.delete();
    drive(1'b1, ONE, ONE, 1'b0, 1'b1, 1'b1, acc);
    drive(1'b1, ONE, 32'h3FC0_0000, 1'b0, 1'b1, 1'b1, acc);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_pre_b: out_valid %b want 0", out_valid);
    end
    // Third operation presented on the same edge that samples reset low
    drive(1'b1, ONE, ONE, 1'b1, 1'b1, 1'b0, acc);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_pre_c: out_valid %b want 0", out_valid);
    end
    drive(1'b1, ONE, 32'h3FC0_0000, 1'b0, 1'b1, 1'b1, acc);
    total++;
    if (out_valid !== 1'b0 || result !== '0 || flags !== '0) begin
      bad++;
      $display("FAIL flush_after_reset: valid %b result %h flags %b want 0/0/0", out_valid,
               result, flags);
    end
    total++;
    if (acc !== 1'b1) begin
      bad++;
      $display("FAIL flush_in_ready: got %b want 1", in_ready);
    end
    got = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
      if (out_valid) begin
        total++;
        if (got) begin
          bad++;
          $display("FAIL flush_extra: cycle %0d result %h", c, result);
        end else begin
          got = 1'b1;
          if (c != 3 || result !== 32'h4020_0000 || flags !== 5'b00000) begin
            bad++;
            $display("FAIL flush_new_op: cycle %0d result %h flags %b want cycle 3 %h %b", c,
                     result, flags, 32'h4020_0000, 5'b00000);
          end
        end
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL flush_timeout: no result after reset");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
